// File: rtl/config_loader_pkg.sv
`default_nettype none
// ============================================================================
// config_loader_pkg : shared state encoding, CRC-8 polynomial and default sizes
// Revision 1.0
// ============================================================================
package config_loader_pkg;

    localparam int DEFAULT_CONFIG_WIDTH = 112;
    localparam int DEFAULT_WORD_WIDTH   = 8;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage : config_loader_pkg
`default_nettype wire

// File: rtl/config_crc8.sv
`default_nettype none
// ============================================================================
// config_crc8 : one-word combinational CRC-8 update, word processed MSB-first
// Revision 1.0
// ============================================================================
module config_crc8
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic [7:0]            crc_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [7:0]            crc_o
);

    logic [7:0] w_crc;

    always_comb begin
        w_crc = crc_i;
        for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
            if (w_crc[7] ^ data_i[i]) begin
                w_crc = {w_crc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                w_crc = {w_crc[6:0], 1'b0};
            end
        end
        crc_o = w_crc;
    end

endmodule : config_crc8
`default_nettype wire

// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
// config_loader : assembles a bitstream into a shadow image, commits atomically
// Optional CRC-8 trailer check enabled by macro CONFIG_LOADER_CRC_EN
// Revision 1.0
// ============================================================================
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CONFIG_WIDTH = DEFAULT_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    cfg_start,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    config_error,
    output logic                    busy
);

    localparam int c_nwords = CONFIG_WIDTH / WORD_WIDTH;
`ifdef CONFIG_LOADER_CRC_EN
    localparam int c_nload  = c_nwords + 1;
`else
    localparam int c_nload  = c_nwords;
`endif
    localparam int c_cnt_w  = (c_nload > 1) ? $clog2(c_nload) : 1;
    localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_nload - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t                  state_q;
    logic [c_cnt_w-1:0]      cnt_q;
    logic [CONFIG_WIDTH-1:0] shadow_q;
    logic [CONFIG_WIDTH-1:0] config_q;
    logic                    done_q;
    logic                    ready_q;
    logic                    busy_q;

`ifdef CONFIG_LOADER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] crc_rx_q;
    logic       error_q;

    config_crc8 #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_crc8 (
        .crc_i  (crc_q),
        .data_i (data_in),
        .crc_o  (crc_d)
    );
`endif

    // Restart has priority over everything, including a coincident word.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            config_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q    <= '0;
            crc_rx_q <= '0;
            error_q  <= 1'b0;
`endif
        end else if (cfg_start) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                ST_LOAD: begin
                    if (data_valid && ready_q) begin
                        for (int k = 0; k < c_nwords; k++) begin
                            if (int'(cnt_q) == k) begin
                                shadow_q[k*WORD_WIDTH +: WORD_WIDTH] <= data_in;
                            end
                        end
`ifdef CONFIG_LOADER_CRC_EN
                        if (int'(cnt_q) < c_nwords) begin
                            crc_q <= crc_d;
                        end else begin
                            crc_rx_q <= 8'(data_in);
                        end
`endif
                        if (cnt_q == c_last_idx) begin
                            state_q <= ST_CHECK;
                            ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + c_cnt_one;
                        end
                    end
                end
                ST_CHECK: begin
`ifdef CONFIG_LOADER_CRC_EN
                    if (crc_q == crc_rx_q) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= ST_COMMIT;
`endif
                end
                ST_COMMIT: begin
                    config_q <= shadow_q;
                    done_q   <= 1'b1;
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready  = ready_q;
    assign config_out  = config_q;
    assign config_done = done_q;
    assign busy        = busy_q;
`ifdef CONFIG_LOADER_CRC_EN
    assign config_error = error_q;
`else
    assign config_error = 1'b0;
`endif

endmodule : config_loader
`default_nettype wire

// File: tb/tb_config_loader.sv
`default_nettype none
// ============================================================================
// tb_config_loader : directed self-checking bench for config_loader
// Revision 1.0
// ============================================================================
module tb_config_loader;

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic         cfg_start = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic         data_valid = 1'b0;
    logic         data_ready;
    logic [111:0] config_out;
    logic         config_done;
    logic         config_error;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [111:0] exp_cfg;

    config_loader #(
        .CONFIG_WIDTH (112),
        .WORD_WIDTH   (8)
    ) dut (
        .clock        (clock),
        .nreset       (nreset),
        .cfg_start    (cfg_start),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .config_out   (config_out),
        .config_done  (config_done),
        .config_error (config_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference CRC-8 (poly 0x07, init 0), bit-serial over 14 bytes, MSB-first
    function automatic logic [7:0] crc8_img(input logic [111:0] img);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int k = 0; k < 14; k++) begin
            b = img[8*k +: 8];
            for (int i = 7; i >= 0; i--) begin
                if (c[7] ^ b[i]) c = {c[6:0], 1'b0} ^ 8'h07;
                else             c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_busy",  busy, 1);
        check("start_ready", data_ready, 1);
        check("start_done",  config_done, 0);
        check("start_error", config_error, 0);
    endtask

    // nw words of img; with the CRC build a full load also sends crcw
    task automatic feed(input logic [111:0] img, input int nw, input bit gaps, input logic [7:0] crcw);
        int  k     = 0;
        int  cyc   = 0;
        int  total = nw;
        bit  ph    = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
        if (nw == 14) total = 15;
`endif
        while (k < total && cyc < 200) begin
            if (gaps && ph) begin
                data_valid = 1'b0;
                data_in    = 8'hEE;
            end else begin
                check("ready_in_load", data_ready, 1);
                data_valid = 1'b1;
                data_in    = (k < 14) ? img[8*k +: 8] : crcw;
                k++;
            end
            ph = !ph;
            tick();
            cyc++;
        end
        data_valid = 1'b0;
        data_in    = 8'h00;
        check("feed_budget", k, total);
    endtask

    // Called right after the final word's edge: CHECK, COMMIT, then visible
    task automatic finish_ok(input logic [111:0] img);
        check("chk_ready", data_ready, 0);
        check("chk_busy",  busy, 1);
        check("chk_done",  config_done, 0);
        check("chk_held",  config_out, exp_cfg);
        tick();
        check("commit_done", config_done, 0);
        check("commit_held", config_out, exp_cfg);
        tick();
        check("done",      config_done, 1);
        check("done_busy", busy, 0);
        check("cfg_out",   config_out, img);
        check("done_err",  config_error, 0);
        exp_cfg = img;
    endtask

    logic [111:0] img_basic, img_ff, img_a5, img_3, img_0;

    initial begin
        for (int k = 0; k < 14; k++) begin
            img_basic[8*k +: 8] = 8'(k);
            img_ff[8*k +: 8]    = 8'hFF;
            img_a5[8*k +: 8]    = 8'hA5;
            img_3[8*k +: 8]     = 8'(k * 17 + 3);
            img_0[8*k +: 8]     = 8'h00;
        end
        exp_cfg = '0;

        // Reset
        nreset = 1'b0;
        tick();
        tick();
        check("rst_cfg",   config_out, 0);
        check("rst_done",  config_done, 0);
        check("rst_err",   config_error, 0);
        check("rst_busy",  busy, 0);
        check("rst_ready", data_ready, 0);
        nreset = 1'b1;
        tick();

        // Basic contiguous load
        start_load();
        feed(img_basic, 14, 1'b0, crc8_img(img_basic));
        finish_ok(img_basic);
        check("basic_lo", config_out[7:0], 8'h00);
        check("basic_hi", config_out[111:104], 8'h0D);

        // Valid ignored in IDLE
        data_valid = 1'b1;
        data_in    = 8'h55;
        tick();
        tick();
        data_valid = 1'b0;
        check("idle_cfg",   config_out, exp_cfg);
        check("idle_busy",  busy, 0);
        check("idle_ready", data_ready, 0);
        check("idle_done",  config_done, 1);

        // Gapped data_valid, same image
        start_load();
        feed(img_basic, 14, 1'b1, crc8_img(img_basic));
        finish_ok(img_basic);

        // Restart after 5 words, coincident with a valid word
        start_load();
        feed(img_ff, 5, 1'b0, 8'h00);
        cfg_start  = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        cfg_start  = 1'b0;
        data_valid = 1'b0;
        check("rs_held",  config_out, exp_cfg);
        check("rs_done",  config_done, 0);
        check("rs_busy",  busy, 1);
        check("rs_ready", data_ready, 1);
        feed(img_a5, 14, 1'b0, crc8_img(img_a5));
        finish_ok(img_a5);

        // Reset mid-load
        start_load();
        feed(img_3, 7, 1'b0, 8'h00);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("mr_cfg",   config_out, 0);
        check("mr_done",  config_done, 0);
        check("mr_busy",  busy, 0);
        check("mr_ready", data_ready, 0);
        exp_cfg = '0;
        tick();
        start_load();
        feed(img_3, 14, 1'b0, crc8_img(img_3));
        finish_ok(img_3);

`ifdef CONFIG_LOADER_CRC_EN
        // All-zero image with CRC 0x00 commits
        start_load();
        feed(img_0, 14, 1'b0, 8'h00);
        finish_ok(img_0);
        start_load();
        feed(img_3, 14, 1'b0, crc8_img(img_3));
        finish_ok(img_3);
        // Bad CRC: error, image held, back to IDLE
        start_load();
        feed(img_0, 14, 1'b0, 8'h01);
        check("bad_chk_busy", busy, 1);
        tick();
        check("bad_err",  config_error, 1);
        check("bad_cfg",  config_out, exp_cfg);
        check("bad_done", config_done, 0);
        check("bad_busy", busy, 0);
        tick();
        check("bad_err_sticky", config_error, 1);
        check("bad_cfg_held",   config_out, exp_cfg);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_config_loader
`default_nettype wire
